// File: rtl/ext_unit_pipe.sv
// Immediate/operand extension unit between decode and execute: zero/sign extend
// with optional fixed left shift, buffered by a two-entry skid (M drives out_*, S catches overflow).
module ext_unit_pipe #(
  parameter int unsigned AB = 11,
  parameter int unsigned DB = 16,
  parameter int unsigned SH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AB-1:0] in_addr,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DB-1:0] out_data,
  output logic          out_trunc
);

  localparam int unsigned MSB_IDX = DB - 1 - SH;
  localparam logic [DB-1:0] LO_MASK = DB'({AB{1'b1}});

  typedef struct packed {
    logic          trunc;
    logic [DB-1:0] data;
  } res_t;

  res_t m_q, m_d, s_q, s_d, res_c;
  logic m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [DB-1:0] ext_c;
  logic lost_z_c, lost_s_c;
  logic accept_c, fire_c;

  // Extension, shift and loss detection for the field currently offered.
  always_comb begin
    ext_c = DB'(in_addr);
    if (in_mode[0] && in_addr[AB-1]) begin
      ext_c = ext_c | ~LO_MASK;
    end
    lost_z_c = 1'b0;
    lost_s_c = 1'b0;
    for (int i = int'(DB - SH); i < int'(DB); i++) begin
      lost_z_c = lost_z_c | ext_c[i];
      lost_s_c = lost_s_c | (ext_c[i] ^ ext_c[MSB_IDX]);
    end
    res_c.data  = in_mode[1] ? (ext_c << SH) : ext_c;
    res_c.trunc = in_mode[1] & (in_mode[0] ? lost_s_c : lost_z_c);
  end

  assign accept_c = in_valid && !s_valid_q;
  assign fire_c   = m_valid_q && out_ready;

  // Skid buffer next-state; accept never coincides with S valid.
  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    if (fire_c) begin
      if (s_valid_q) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = 1'b0;
      end
    end
    if (accept_c) begin
      if (!m_valid_q || fire_c) begin
        m_d       = res_c;
        m_valid_d = 1'b1;
      end else begin
        s_d       = res_c;
        s_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_q.data;
  assign out_trunc = m_q.trunc;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Scoreboard bench for ext_unit_pipe: default instance plus a 16/16/4 instance for shift/trunc corners.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_addr = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_trunc;

  logic        in_valid_w = 1'b0;
  logic        in_ready_w;
  logic [15:0] in_addr_w = '0;
  logic [1:0]  in_mode_w = '0;
  logic        out_valid_w;
  logic        out_ready_w = 1'b1;
  logic [15:0] out_data_w;
  logic        out_trunc_w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_w[$];

  ext_unit_pipe u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_trunc(out_trunc)
  );

  ext_unit_pipe #(.AB(16), .DB(16), .SH(4)) u_wide (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_addr(in_addr_w), .in_mode(in_mode_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w), .out_trunc(out_trunc_w)
  );

  always #5 clk = ~clk;

  // Reference: extend into 32 bits, shift, then judge loss as non-representability in 16 bits.
  function automatic logic [16:0] model(input int ab, input int sh, input logic [15:0] a,
                                        input logic [1:0] m);
    logic [31:0] mask, e, r;
    logic t;
    mask = (32'd1 << ab) - 32'd1;
    e = {16'd0, a} & mask;
    if (m[0] && a[ab-1]) e = e | ~mask;
    r = m[1] ? (e << sh) : e;
    if (!m[1])     t = 1'b0;
    else if (m[0]) t = (r != {{16{r[15]}}, r[15:0]});
    else           t = (r[31:16] != 16'd0);
    return {t, r[15:0]};
  endfunction

  // One cycle on the default instance: observe, predict acceptance, drive, advance.
  task automatic cycle(input logic v, input logic [10:0] a, input logic [1:0] m, input logic rdy,
                       input logic [16:0] exp, output logic acc, output logic fire,
                       output logic ov, output logic ir, output logic [16:0] got);
    ov   = out_valid;
    ir   = in_ready;
    got  = {out_trunc, out_data};
    fire = ov && rdy;
    acc  = v && ir && !reset;
    if (acc) exp_q.push_back(exp);
    in_valid  = v;
    in_addr   = a;
    in_mode   = m;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_addr = 11'h7FF; in_mode = 2'b01; out_ready = 1'b0;
    in_valid_w = 1'b1; in_addr_w = 16'hFFFF; in_mode_w = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h need 0000", out_data); end
    n_cmp++; if (out_trunc !== 1'b0) begin n_bad++; $display("FAIL reset_out_trunc: got %b need 0", out_trunc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL reset_wide_valid: got %b need 0", out_valid_w); end
    reset = 1'b0; in_valid = 1'b0; in_valid_w = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept: got out_valid %b need 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [10:0] av[5] = '{11'h400, 11'h400, 11'h400, 11'h400, 11'h7FF};
    logic [1:0]  mv[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [16:0] ev[5] = '{17'h00400, 17'h0FC00, 17'h01000, 17'h0F000, 17'h01FFC};
    logic acc, fire, ov, ir;
    logic [16:0] got, e;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) cycle(1'b1, av[i], mv[i], 1'b1, ev[i], acc, fire, ov, ir, got);
      else       cycle(1'b0, 11'h0, 2'b00, 1'b1, 17'h0, acc, fire, ov, ir, got);
      if (fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL modes_extra: got %h need none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_bad++; $display("FAIL modes_result[%0d]: got %h need %h", i, got, e); end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL modes_lost: got %0d pending need 0", exp_q.size()); end
  endtask

  task automatic test_wide();
    logic [15:0] av[6] = '{16'hF123, 16'h0123, 16'hF923, 16'h8123, 16'h8123, 16'h8123};
    logic [1:0]  mv[6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic [16:0] ev[6] = '{17'h11230, 17'h01230, 17'h09230, 17'h11230, 17'h0FFFF & 17'h08123, 17'h08123};
    logic [16:0] got, e;
    out_ready_w = 1'b1;
    for (int i = 0; i < 7; i++) begin
      got = {out_trunc_w, out_data_w};
      if (out_valid_w) begin
        n_cmp++;
        if (exp_w.size() == 0) begin n_bad++; $display("FAIL wide_extra: got %h need none", got); end
        else begin
          e = exp_w.pop_front();
          if (got !== e) begin n_bad++; $display("FAIL wide_result: got %h need %h", got, e); end
        end
      end
      if (i < 6 && in_ready_w) exp_w.push_back(ev[i]);
      in_valid_w = (i < 6);
      in_addr_w  = (i < 6) ? av[i] : 16'h0;
      in_mode_w  = (i < 6) ? mv[i] : 2'b00;
      @(posedge clk);
      #1;
    end
    in_valid_w = 1'b0;
    n_cmp++; if (exp_w.size() != 0) begin n_bad++; $display("FAIL wide_lost: got %0d pending need 0", exp_w.size()); end
  endtask

  task automatic test_backpressure();
    logic acc, fire, ov, ir, sent3;
    logic [16:0] got, e;
    cycle(1'b1, 11'h001, 2'b00, 1'b0, 17'h00001, acc, fire, ov, ir, got);
    n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready: got %b need 1", ir); end
    cycle(1'b1, 11'h002, 2'b00, 1'b0, 17'h00002, acc, fire, ov, ir, got);
    n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL bp_second_ready: got %b need 1", ir); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 11'h003, 2'b00, 1'b0, 17'h00003, acc, fire, ov, ir, got);
      n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b need 0", ir); end
      n_cmp++; if (ov !== 1'b1 || got !== 17'h00001) begin
        n_bad++; $display("FAIL bp_hold: got v=%b %h need v=1 00001", ov, got);
      end
    end
    sent3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(!sent3, 11'h003, 2'b00, 1'b1, 17'h00003, acc, fire, ov, ir, got);
      if (acc) sent3 = 1'b1;
      if (k == 1) begin
        n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: got %b need 1", ir); end
      end
      if (fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h need none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_bad++; $display("FAIL bp_order: got %h need %h", got, e); end
        end
      end
    end
    n_cmp++; if (!sent3 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL bp_drain: got sent=%b pending=%0d need sent=1 pending=0", sent3, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic acc, fire, ov, ir;
    logic [16:0] got, e;
    logic [10:0] a;
    logic [1:0] m;
    for (int i = 0; i < 9; i++) begin
      a = 11'($urandom);
      m = 2'(i % 4);
      cycle(i < 8, a, m, 1'b1, model(11, 2, {5'd0, a}, m), acc, fire, ov, ir, got);
      n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d]: got %b need 1", i, ir); end
      if (i > 0) begin
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL stream_latency[%0d]: got %b need 1", i, ov); end
      end
      if (fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL stream_extra: got %h need none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_bad++; $display("FAIL stream_result[%0d]: got %h need %h", i, got, e); end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_lost: got %0d pending need 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    logic acc, fire, ov, ir;
    logic [16:0] got, e;
    cycle(1'b1, 11'h011, 2'b00, 1'b0, 17'h00011, acc, fire, ov, ir, got);
    cycle(1'b1, 11'h012, 2'b00, 1'b0, 17'h00012, acc, fire, ov, ir, got);
    reset = 1'b1;
    cycle(1'b0, 11'h0, 2'b00, 1'b0, 17'h0, acc, fire, ov, ir, got);
    n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL mrst_full: got in_ready %b need 0", ir); end
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(k == 3, 11'h455, 2'b01, 1'b1, 17'h0FC55, acc, fire, ov, ir, got);
      n_cmp++; if (ov !== 1'b0 || ir !== 1'b1) begin
        n_bad++; $display("FAIL mrst_cleared[%0d]: got v=%b r=%b need v=0 r=1", k, ov, ir);
      end
    end
    cycle(1'b0, 11'h0, 2'b00, 1'b1, 17'h0, acc, fire, ov, ir, got);
    n_cmp++;
    if (!fire || exp_q.size() == 0) begin n_bad++; $display("FAIL mrst_resume: got v=%b need v=1", ov); end
    else begin
      e = exp_q.pop_front();
      if (got !== e) begin n_bad++; $display("FAIL mrst_resume_data: got %h need %h", got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_wide();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
